// File: rtl/gb_clock_enable_gen.sv
// Game Boy machine clock-enable generator for the clk_sys domain.
// Settles PLL lock into a core reset and emits ce / ce_n / ce_2x with speed, fast-forward and pause modes.
module gb_clock_enable_gen #(
  parameter int unsigned DIV_LOG2  = 4,
  parameter int unsigned FF_SHIFT  = 2,
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic speed,
  input  logic fast_fwd,
  input  logic pause_req,
  output logic pause_ack,
  output logic core_reset,
  output logic ce,
  output logic ce_n,
  output logic ce_2x
);

  localparam int unsigned DW = DIV_LOG2;
  localparam int unsigned PW = $clog2(DIV_LOG2 + 1);
  localparam int unsigned CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2,
    PAUSED    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   plog_q, plog_d;
  logic            lock_meta_q, lock_sync_q;
  logic            ce_q, ce_d;
  logic            ce_n_q, ce_n_d;
  logic            ce_2x_q, ce_2x_d;
  logic            pause_ack_q, pause_ack_d;
  logic            core_reset_q, core_reset_d;
  logic            run_d;

  // log2 of the ce period for a given mode, never below 1
  function automatic logic [PW-1:0] plog_of(input logic spd, input logic ff);
    int v;
    v = int'(DIV_LOG2);
    if (spd) v = v - 1;
    if (ff)  v = v - int'(FF_SHIFT);
    if (v < 1) v = 1;
    return PW'(v);
  endfunction

  function automatic logic [DW-1:0] last_of(input logic [PW-1:0] p);
    return DW'((32'd1 << p) - 32'd1);
  endfunction

  function automatic logic [DW-1:0] half_of(input logic [PW-1:0] p);
    return DW'((32'd1 << (p - PW'(1))) - 32'd1);
  endfunction

  // Two-flop synchroniser for the asynchronous PLL lock flag
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      div_q        <= '0;
      cnt_q        <= '0;
      plog_q       <= PW'(DIV_LOG2);
      ce_q         <= 1'b0;
      ce_n_q       <= 1'b0;
      ce_2x_q      <= 1'b0;
      pause_ack_q  <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      plog_q       <= plog_d;
      ce_q         <= ce_d;
      ce_n_q       <= ce_n_d;
      ce_2x_q      <= ce_2x_d;
      pause_ack_q  <= pause_ack_d;
      core_reset_q <= core_reset_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    plog_d  = plog_q;

    case (state_q)
      WAIT_LOCK: begin
        div_d = '0;
        if (lock_sync_q) begin
          state_d = SETTLE;
          cnt_d   = CW'(LOCK_WAIT - 1);
        end
      end
      SETTLE: begin
        div_d = '0;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RUN: begin
        // Mode and pause are only sampled on the ce cycle so periods never get cut short
        if (div_q == last_of(plog_q)) begin
          div_d  = '0;
          plog_d = plog_of(speed, fast_fwd);
          if (pause_req) state_d = PAUSED;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      PAUSED: begin
        div_d = '0;
        if (!pause_req) state_d = RUN;
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Lock loss overrides everything except the async reset
    if (!lock_sync_q) begin
      state_d = WAIT_LOCK;
      div_d   = '0;
    end

    // Outputs are registered, so decode them from the next-state values
    run_d        = (state_d == RUN);
    ce_d         = run_d && (div_d == last_of(plog_d));
    ce_n_d       = run_d && (div_d == half_of(plog_d));
    ce_2x_d      = ce_d || ce_n_d;
    pause_ack_d  = (state_d == PAUSED);
    core_reset_d = !(run_d || pause_ack_d);
  end

  assign ce         = ce_q;
  assign ce_n       = ce_n_q;
  assign ce_2x      = ce_2x_q;
  assign pause_ack  = pause_ack_q;
  assign core_reset = core_reset_q;

endmodule

// File: tb/tb_gb_clock_enable_gen.sv
// Self-checking bench for gb_clock_enable_gen: ce-gap scoreboard, mode-change table, pause, lock loss, async reset.
module tb_gb_clock_enable_gen;

  localparam int unsigned LW = 16;

  logic clk_sys = 1'b0;
  logic rst_n, pll_locked, speed, fast_fwd, pause_req;
  logic pause_ack, core_reset, ce, ce_n, ce_2x;

  gb_clock_enable_gen #(.DIV_LOG2(4), .FF_SHIFT(2), .LOCK_WAIT(LW)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .speed      (speed),
    .fast_fwd   (fast_fwd),
    .pause_req  (pause_req),
    .pause_ack  (pause_ack),
    .core_reset (core_reset),
    .ce         (ce),
    .ce_n       (ce_n),
    .ce_2x      (ce_2x)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_ce = 0;
  int last_cen = 0;
  int exp_q[$];
  logic prev_rst = 1'b1;
  logic prev_ack = 1'b0;

  typedef struct {
    logic spd;
    logic ff;
    int   dly;
    int   exp_p;
  } vec_t;

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: ce gaps and ce->ce_n offsets against the scoreboard queue
  initial begin
    forever begin
      int e;
      @(negedge clk_sys);
      cyc++;
      check("ce_2x_is_or", int'(ce_2x), int'(ce | ce_n));
      if (core_reset || pause_ack) check("quiet_enables", int'({ce, ce_n}), 0);
      if (prev_rst && !core_reset) last_ce = cyc - 1;
      if (prev_ack && !pause_ack && !core_reset) last_ce = cyc - 1;
      if (ce_n) last_cen = cyc;
      if (ce) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("ce_gap", cyc - last_ce, e);
          check("ce_n_to_ce", cyc - last_cen, e / 2);
        end
        last_ce = cyc;
      end
      prev_rst = core_reset;
      prev_ack = pause_ack;
    end
  end

  task automatic wait_ce();
    int k;
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (!ce && k < 200);
    check("wait_ce", int'(ce), 1);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    check("scoreboard_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   cur_p;
    int   n;

    tbl[0] = '{spd: 1'b1, ff: 1'b0, dly: 4, exp_p: 8};
    tbl[1] = '{spd: 1'b0, ff: 1'b1, dly: 1, exp_p: 4};
    tbl[2] = '{spd: 1'b1, ff: 1'b1, dly: 1, exp_p: 2};
    tbl[3] = '{spd: 1'b0, ff: 1'b0, dly: 1, exp_p: 16};
    tbl[4] = '{spd: 1'b1, ff: 1'b1, dly: 4, exp_p: 2};
    tbl[5] = '{spd: 1'b0, ff: 1'b0, dly: 1, exp_p: 16};

    rst_n = 1'b0; pll_locked = 1'b1; speed = 1'b0; fast_fwd = 1'b0; pause_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_core_reset", int'(core_reset), 1);
    check("rst_ce", int'(ce), 0);
    check("rst_ce_n", int'(ce_n), 0);
    check("rst_ce_2x", int'(ce_2x), 0);
    check("rst_pause_ack", int'(pause_ack), 0);

    // Bring-up: 2 sync + LW settle + 1 lock-detect cycle, then three normal periods
    repeat (3) exp_q.push_back(16);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (core_reset && n < 100);
    check("lock_to_run", n, 2 + LW + 1);
    wait_drain(200);

    // Mode changes take effect only after the period in progress
    cur_p = 16;
    for (int i = 0; i < 6; i++) begin
      wait_ce();
      repeat (tbl[i].dly) @(negedge clk_sys);
      speed    = tbl[i].spd;
      fast_fwd = tbl[i].ff;
      exp_q.push_back(cur_p);
      repeat (3) exp_q.push_back(tbl[i].exp_p);
      wait_drain(200);
      cur_p = tbl[i].exp_p;
    end

    // Pause requested at div=5 completes the period, then freezes
    wait_ce();
    repeat (6) @(negedge clk_sys);
    pause_req = 1'b1;
    exp_q.push_back(16);
    wait_ce();
    @(negedge clk_sys);
    check("pause_ack_rise", int'(pause_ack), 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      check("pause_ack_hold", int'(pause_ack), 1);
    end
    pause_req = 1'b0;
    exp_q.push_back(16);
    exp_q.push_back(16);
    @(negedge clk_sys);
    check("pause_ack_fall", int'(pause_ack), 0);
    check("pause_no_reset", int'(core_reset), 0);
    wait_drain(200);

    // A pause pulse that misses the ce cycle is ignored
    wait_ce();
    repeat (6) @(negedge clk_sys);
    pause_req = 1'b1;
    @(negedge clk_sys);
    pause_req = 1'b0;
    exp_q.push_back(16);
    exp_q.push_back(16);
    wait_drain(200);
    check("pulse_ignored", int'(pause_ack), 0);

    // One-cycle lock drop mid-RUN, then full settle again
    wait_ce();
    repeat (3) @(negedge clk_sys);
    pll_locked = 1'b0;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
      if (n == 1) pll_locked = 1'b1;
    end while (!core_reset && n < 10);
    check("lockloss_latency", n, 3);
    check("lockloss_ce", int'(ce | ce_n), 0);
    check("lockloss_ack", int'(pause_ack), 0);
    exp_q.push_back(16);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (core_reset && n < 100);
    check("relock_settle", n, LW + 1);
    wait_drain(200);

    // Async reset asserted inside a ce cycle, between clock edges
    wait_ce();
    #1 rst_n = 1'b0;
    #1;
    check("async_core_reset", int'(core_reset), 1);
    check("async_ce", int'(ce), 0);
    check("async_ce_n", int'(ce_n), 0);
    check("async_ce_2x", int'(ce_2x), 0);
    check("async_pause_ack", int'(pause_ack), 0);
    @(negedge clk_sys);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
